// File: rtl/yarvi_alu_stage_if.sv
// Execute-stage handshake bundle: operand/op side toward the stage,
// result side back to writeback, valid/ready on both.
interface yarvi_alu_stage_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic             in_insn30;
    logic             in_op32;
    logic             in_fwd1;
    logic             in_fwd2;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_funct3, in_insn30, in_op32,
        output in_fwd1, in_fwd2, in_rs1, in_rs2, in_tag,
        output out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_funct3, in_insn30, in_op32,
        input  in_fwd1, in_fwd2, in_rs1, in_rs2, in_tag,
        input  out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/yarvi_alu_stage.sv
// Registered RISC-V integer execute stage with self-forwarding,
// RV64 word ops and a pass-through writeback tag.
module yarvi_alu_stage #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input logic              clock,
    input logic              reset,
    yarvi_alu_stage_if.slave io
);
    localparam bit HAS_W = (XLEN == 64);

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  fwd_q, fwd_d;

    logic             accept;
    logic [XLEN-1:0]  op1, op2;
    logic             is_word;
    logic [5:0]       shamt;
    logic [XLEN-1:0]  full_res;
    logic [31:0]      w1, w2, wres;
    logic [XLEN-1:0]  wext;
    logic [XLEN-1:0]  alu_res;

    // A held result only blocks us while downstream stalls; reset
    // forces ready so nothing upstream sees a stale stall.
    assign io.in_ready = !valid_q || io.out_ready || reset;
    assign accept      = io.in_valid && io.in_ready && !reset;

    assign io.out_valid  = valid_q;
    assign io.out_result = result_q;
    assign io.out_tag    = tag_q;

    always_comb begin
        op1 = io.in_fwd1 ? fwd_q : io.in_rs1;
        op2 = io.in_fwd2 ? fwd_q : io.in_rs2;
        is_word = 1'b0;
        if (HAS_W && io.in_op32) begin
            unique case (io.in_funct3)
                3'd0, 3'd1, 3'd5: is_word = 1'b1;
                default:          is_word = 1'b0;
            endcase
        end
        if (XLEN == 64 && !is_word) begin
            shamt = op2[5:0];
        end else begin
            shamt = {1'b0, op2[4:0]};
        end
        w1 = op1[31:0];
        w2 = op2[31:0];
    end

    always_comb begin
        full_res = '0;
        unique case (io.in_funct3)
            3'd0: full_res = io.in_insn30 ? op1 - op2 : op1 + op2;
            3'd1: full_res = op1 << shamt;
            3'd2: full_res = {{(XLEN-1){1'b0}},
                              $signed(op1) < $signed(op2)};
            3'd3: full_res = {{(XLEN-1){1'b0}}, op1 < op2};
            3'd4: full_res = op1 ^ op2;
            3'd5: begin
                if (io.in_insn30) begin
                    full_res = $unsigned($signed(op1) >>> shamt);
                end else begin
                    full_res = op1 >> shamt;
                end
            end
            3'd6: full_res = op1 | op2;
            3'd7: full_res = op1 & op2;
            default: full_res = '0;
        endcase
    end

    always_comb begin
        wres = '0;
        unique case (io.in_funct3)
            3'd0: wres = io.in_insn30 ? w1 - w2 : w1 + w2;
            3'd1: wres = w1 << shamt[4:0];
            3'd5: begin
                if (io.in_insn30) begin
                    wres = $unsigned($signed(w1) >>> shamt[4:0]);
                end else begin
                    wres = w1 >> shamt[4:0];
                end
            end
            default: wres = '0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wext
            assign wext = {{(XLEN-32){wres[31]}}, wres};
        end else begin : g_nowext
            assign wext = wres;
        end
    endgenerate

    assign alu_res = is_word ? wext : full_res;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        tag_d    = tag_q;
        fwd_d    = fwd_q;
        if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            tag_d    = io.in_tag;
            fwd_d    = alu_res;
        end else if (io.out_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
            fwd_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            fwd_q    <= fwd_d;
        end
    end
endmodule

// File: tb/tb_yarvi_alu_stage.sv
// Directed-vector bench for yarvi_alu_stage (XLEN=64 main instance,
// XLEN=32 side instance for the narrow shift corner).
module tb_yarvi_alu_stage;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    yarvi_alu_stage_if #(.XLEN(64), .TAG_W(5)) bus ();
    yarvi_alu_stage_if #(.XLEN(32), .TAG_W(5)) bus32 ();

    yarvi_alu_stage #(.XLEN(64), .TAG_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    yarvi_alu_stage #(.XLEN(32), .TAG_W(5)) dut32 (
        .clock (clock),
        .reset (reset),
        .io    (bus32)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        i30;
        logic        w;
        logic        f1;
        logic        f2;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [4:0]  tag;
        logic        gap;
        logic [63:0] exp;
    } vec_t;

    int   n_err = 0;
    int   n_chk = 0;
    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [2:0] f3, input logic i30, input logic w,
        input logic f1, input logic f2,
        input logic [63:0] rs1, input logic [63:0] rs2,
        input logic [4:0] tag, input logic gap,
        input logic [63:0] exp);
        vec_t v;
        v.f3 = f3; v.i30 = i30; v.w = w; v.f1 = f1; v.f2 = f2;
        v.rs1 = rs1; v.rs2 = rs2; v.tag = tag; v.gap = gap;
        v.exp = exp;
        return v;
    endfunction

    task automatic drive(input logic [2:0] f3, input logic i30,
                         input logic w, input logic f1,
                         input logic f2, input logic [63:0] rs1,
                         input logic [63:0] rs2,
                         input logic [4:0] tag);
        bus.in_valid  = 1'b1;
        bus.in_funct3 = f3;
        bus.in_insn30 = i30;
        bus.in_op32   = w;
        bus.in_fwd1   = f1;
        bus.in_fwd2   = f2;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_tag    = tag;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 64'd1, 5'd1);
        bus.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in_funct3 = 3'd0;
        bus32.in_insn30 = 1'b0;
        bus32.in_op32   = 1'b0;
        bus32.in_fwd1   = 1'b0;
        bus32.in_fwd2   = 1'b0;
        bus32.in_rs1    = '0;
        bus32.in_rs2    = '0;
        bus32.in_tag    = '0;

        vt.push_back(mk(0, 0, 0, 0, 0, 5, 7, 5'h13, 0, 64'd12));
        vt.push_back(mk(0, 1, 0, 0, 0, 5, 7, 5'h13, 0,
                        64'hFFFF_FFFF_FFFF_FFFE));
        vt.push_back(mk(0, 0, 1, 0, 0, 64'h7FFF_FFFF, 1, 5'h02, 0,
                        64'hFFFF_FFFF_8000_0000));
        vt.push_back(mk(5, 1, 1, 0, 0, 64'h8000_0000, 4, 5'h03, 0,
                        64'hFFFF_FFFF_F800_0000));
        vt.push_back(mk(1, 0, 1, 0, 0, 1, 64'h3F, 5'h04, 0,
                        64'hFFFF_FFFF_8000_0000));
        vt.push_back(mk(2, 0, 0, 0, 0, '1, 1, 5'h05, 0, 64'd1));
        vt.push_back(mk(3, 0, 0, 0, 0, '1, 1, 5'h06, 0, 64'd0));
        vt.push_back(mk(5, 1, 0, 0, 0, 64'h8000_0000_0000_0000, 63,
                        5'h07, 0, '1));
        vt.push_back(mk(5, 0, 0, 0, 0, 64'h8000_0000_0000_0000, 63,
                        5'h08, 0, 64'd1));
        vt.push_back(mk(4, 0, 0, 0, 0, 64'hF0F0, 64'hFF00, 5'h09, 0,
                        64'h0FF0));
        vt.push_back(mk(6, 0, 0, 0, 0, 64'hF0F0, 64'h0F0F, 5'h0A, 0,
                        64'hFFFF));
        vt.push_back(mk(7, 0, 0, 0, 0, 64'hFF00, 64'h0FF0, 5'h0B, 0,
                        64'h0F00));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 63, 5'h0C, 0,
                        64'h8000_0000_0000_0000));
        vt.push_back(mk(7, 0, 1, 0, 0, 64'hFFFF_FFFF_0000_0000, '1,
                        5'h0D, 0, 64'hFFFF_FFFF_0000_0000));
        vt.push_back(mk(2, 1, 0, 0, 0, 1, '1, 5'h0E, 0, 64'd0));
        vt.push_back(mk(0, 0, 0, 0, 0, '1, 2, 5'h0F, 0, 64'd1));
        // forwarding chain back-to-back, then again with idle gaps
        vt.push_back(mk(0, 0, 0, 0, 0, 3, 4, 5'h10, 0, 64'd7));
        vt.push_back(mk(0, 0, 0, 1, 0, 100, 1, 5'h11, 0, 64'd8));
        vt.push_back(mk(0, 0, 0, 1, 1, 100, 1, 5'h12, 0, 64'd16));
        vt.push_back(mk(0, 0, 0, 0, 0, 3, 4, 5'h10, 1, 64'd7));
        vt.push_back(mk(0, 0, 0, 1, 0, 100, 1, 5'h11, 1, 64'd8));
        vt.push_back(mk(0, 0, 0, 1, 1, 100, 1, 5'h12, 1, 64'd16));

        // reset state
        tick();
        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_result", bus.out_result, 64'd0);
        chk("rst_tag", {59'd0, bus.out_tag}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clock);
        reset = 1'b0;

        foreach (vt[i]) begin
            @(negedge clock);
            drive(vt[i].f3, vt[i].i30, vt[i].w, vt[i].f1, vt[i].f2,
                  vt[i].rs1, vt[i].rs2, vt[i].tag);
            tick();
            chk($sformatf("vec%0d_valid", i),
                {63'd0, bus.out_valid}, 64'd1);
            chk($sformatf("vec%0d_result", i),
                bus.out_result, vt[i].exp);
            chk($sformatf("vec%0d_tag", i),
                {59'd0, bus.out_tag}, {59'd0, vt[i].tag});
            if (vt[i].gap) begin
                @(negedge clock);
                bus.in_valid = 1'b0;
                tick();
                chk($sformatf("vec%0d_gap_valid", i),
                    {63'd0, bus.out_valid}, 64'd0);
            end
        end

        // backpressure: stall three cycles, then drain four queued ops
        @(negedge clock);
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd10, 64'd20, 5'd7);
        bus.out_ready = 1'b0;
        tick();
        chk("bp_first", bus.out_result, 64'd30);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 64'd1, 5'd1);
            tick();
            chk($sformatf("bp_in_ready%0d", c),
                {63'd0, bus.in_ready}, 64'd0);
            chk($sformatf("bp_result%0d", c), bus.out_result, 64'd30);
            chk($sformatf("bp_tag%0d", c),
                {59'd0, bus.out_tag}, 64'd7);
            chk($sformatf("bp_valid%0d", c),
                {63'd0, bus.out_valid}, 64'd1);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            bus.out_ready = 1'b1;
            drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'(k), 64'(k),
                  5'(k));
            tick();
            chk($sformatf("drain%0d_valid", k),
                {63'd0, bus.out_valid}, 64'd1);
            chk($sformatf("drain%0d_result", k),
                bus.out_result, 64'(2 * k));
            chk($sformatf("drain%0d_tag", k),
                {59'd0, bus.out_tag}, 64'(k));
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        tick();
        chk("consume_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("consume_hold", bus.out_result, 64'd8);

        // reset while a result is held
        @(negedge clock);
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h55, 64'd0, 5'd9);
        bus.out_ready = 1'b0;
        tick();
        chk("mid_held", bus.out_result, 64'h55);
        @(negedge clock);
        reset = 1'b1;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd9, 64'd9, 5'd3);
        #1;
        chk("mid_rdy_in_rst", {63'd0, bus.in_ready}, 64'd1);
        tick();
        chk("mid_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid_result", bus.out_result, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("mid_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clock);
        drive(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd999, 64'd5, 5'd4);
        tick();
        chk("mid_fwd_zero", bus.out_result, 64'd5);
        chk("mid_fwd_valid", {63'd0, bus.out_valid}, 64'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;

        // XLEN=32 instance: 5-bit shamt, op32 ignored
        @(negedge clock);
        bus32.in_valid  = 1'b1;
        bus32.in_funct3 = 3'd5;
        bus32.in_insn30 = 1'b1;
        bus32.in_rs1    = 32'h8000_0000;
        bus32.in_rs2    = 32'd31;
        bus32.in_tag    = 5'd2;
        tick();
        chk("x32_sra", {32'd0, bus32.out_result}, 64'hFFFF_FFFF);
        @(negedge clock);
        bus32.in_funct3 = 3'd0;
        bus32.in_insn30 = 1'b0;
        bus32.in_op32   = 1'b1;
        bus32.in_rs1    = 32'hFFFF_FFFF;
        bus32.in_rs2    = 32'd1;
        tick();
        chk("x32_add_wrap", {32'd0, bus32.out_result}, 64'd0);
        @(negedge clock);
        bus32.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/yarvi_alu_stage.md
# yarvi_alu_stage

Parametrised, registered RISC-V integer execute stage: one ALU op per cycle with valid/ready handshakes on both sides, operand forwarding from its own previous result, RV64 word-op (`*W`) support, and a tag passed through for writeback steering. It replaces the fixed 64-bit ALU-plus-forward-mux arrangement with a backpressure-aware pipeline stage between operand read and writeback.

## Interface
- `XLEN`, default 64: datapath width; legal values are 32 and 64.
- `TAG_W`, default 5: width of the pass-through tag (destination register index).
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  stage can accept this cycle.
- `in_funct3`  in  3  RISC-V funct3.
- `in_insn30`  in  1  instruction bit 30: SUB and SRA/SRAW select.
- `in_op32`  in  1  word op (`ADDW`/`SUBW`/`SLLW`/`SRLW`/`SRAW`); ignored when XLEN=32.
- `in_fwd1`, `in_fwd2`  in  1 each  replace rs1 or rs2 with the forward value.
- `in_rs1`, `in_rs2`  in  XLEN each  register-file operands.
- `in_tag`  in  TAG_W  carried to output unchanged.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts this cycle.
- `out_result`  out  XLEN  registered result.
- `out_tag`  out  TAG_W  tag of `out_result`.

## Operation
- Accept condition: `in_valid & in_ready`.
- `in_ready = !out_valid | out_ready`. This is combinational from registered `out_valid` and the `out_ready` input.
- `op1 = in_fwd1 ? fwd_value : in_rs1`.
- `op2 = in_fwd2 ? fwd_value : in_rs2`.
- `fwd_value` is the result of the most recently accepted op. It is held in a register, updated only on accept, and reset to 0. It stays valid after the result has been consumed downstream.
- funct3 decode:
  - 0: ADD, or SUB when `in_insn30`=1.
  - 1: SLL.
  - 2: SLT (signed).
  - 3: SLTU.
  - 4: XOR.
  - 5: SRL, or SRA when `in_insn30`=1.
  - 6: OR.
  - 7: AND.
- `in_insn30` is ignored for funct3 in {1,2,3,4,6,7}.
- Shift amount:
  - `op2[5:0]` for XLEN=64 full-width ops.
  - `op2[4:0]` for XLEN=32 and for word ops.
- Word ops (XLEN=64, `in_op32`=1, funct3 in {0,1,5}):
  - Operate on `op1[31:0]`, `op2[31:0]`.
  - SRAW shifts in `op1[31]`.
  - The 32-bit result is sign-extended from bit 31 to 64 bits.
- `in_op32` is ignored for other funct3 values, which execute as full-width ops.
- SLT/SLTU produce 0 or 1, zero-extended.
- All arithmetic wraps modulo 2^XLEN (2^32 for word ops before sign extension). No overflow flag.
- On accept, the next edge writes `out_result`, `out_tag` and `fwd_value`, and sets `out_valid`=1.
- If there is no accept but `out_ready`=1, the next edge clears `out_valid`. `out_result`/`out_tag` keep their last values.
- While `out_valid & !out_ready`: `out_result`, `out_tag` and `fwd_value` hold stable, and `in_ready`=0.

## Timing
- Latency: 1 cycle. An op accepted at edge N is visible on `out_*` after edge N.
- Throughput: 1 op/cycle whenever `out_ready`=1.
- Simultaneous drain and accept (`out_valid`=1, `out_ready`=1, `in_valid`=1): the old result is consumed and the new op is captured on the same edge, with no bubble.
- Back-to-back dependency: an op accepted on the cycle immediately after its producer sees the producer's result through `in_fwd*` with zero bubbles.
- Reset values: `out_valid`=0, `out_result`=0, `out_tag`=0, `fwd_value`=0. `in_ready`=1 during and after reset.
- Reset asserted mid-operation discards any held result. An op offered in a reset cycle is not accepted.
- No combinational path from `in_*` to `out_*`.

## Test plan
All scenarios use XLEN=64 unless stated.
- **ADD/SUB:** rs1=5, rs2=7, funct3=0 → `out_result`=12 one cycle later. Same operands with insn30=1 → 0xFFFF_FFFF_FFFF_FFFE. Tag 0x13 is echoed on `out_tag`.
- **Word ops:** op32, ADDW of 0x7FFF_FFFF+1 → 0xFFFF_FFFF_8000_0000. SRAW of 0x0000_0000_8000_0000 by 4 → 0xFFFF_FFFF_F800_0000. SLLW with rs2=0x3F shifts by 31 only.
- **Compare/shift:** SLT(-1,1)=1 and SLTU(-1,1)=0. SRA of 0x8000_0000_0000_0000 by 63 → all ones; SRL of the same → 1. Repeat with XLEN=32: SRA of 0x8000_0000 by 31 → 0xFFFF_FFFF.
- **Forwarding chain:** accept 3+4 (→7), then fwd1 with rs1=100, rs2=1 → 8, then fwd1+fwd2 → 16. Repeat with a one-cycle `in_valid` gap between ops: results unchanged.
- **Backpressure:** hold `out_ready`=0 for 3 cycles after a result. `in_ready`=0, and `out_result`/`out_tag` are stable. Release `out_ready` with four queued ops: the four results appear on four consecutive cycles.
- **Reset mid-flight:** with `out_valid`=1 holding 0x55, pulse `reset` for 1 cycle → `out_valid`=0 and `in_ready`=1. Next op fwd1 with rs2=5 (ADD) → 5, proving `fwd_value`=0.
